// File: rtl/binadd_selftest_if.sv
// Bus between the BinAdd self-test engine and the adder under test plus its status sinks.
// The master side is the self-test engine; the slave side is the adder/board wrapper.
interface binadd_selftest_if #(
    parameter int WIDTH = 2,
    parameter int ERR_W = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_in;
    logic             cout_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;
    logic             fail_vld;

    modport master (
        input  start, sum_in, cout_in,
        output op_a, op_b, busy, done, pass, err_cnt, fail_a, fail_b, fail_vld
    );

    modport slave (
        output start, sum_in, cout_in,
        input  op_a, op_b, busy, done, pass, err_cnt, fail_a, fail_b, fail_vld
    );
endinterface

// File: rtl/binadd_selftest.sv
// Exhaustive on-board self-test for the combinational BinAdd adder: sweeps all operand pairs.
// Optional build macro BINADD_SELFTEST_HALT_ON_ERR_EN stops the sweep at the first mismatch.
module binadd_selftest #(
    parameter int WIDTH      = 2,
    parameter int SETTLE_CYC = 4,
    parameter int ERR_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    binadd_selftest_if.master     bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [WIDTH-1:0] OP_ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] OP_ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] OP_ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_ONES    = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ZERO    = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0] ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};

    // Reference result, zero-extended so the carry lands in the top bit.
    function automatic logic [WIDTH:0] expected_sum(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_ONES) ? v : v + ERR_ONE;
    endfunction

    logic [1:0]       state_r,    state_s;
    logic [7:0]       cnt_r,      cnt_s;
    logic [WIDTH-1:0] op_a_r,     op_a_s;
    logic [WIDTH-1:0] op_b_r,     op_b_s;
    logic             busy_r,     busy_s;
    logic             done_r,     done_s;
    logic             pass_r,     pass_s;
    logic [ERR_W-1:0] err_cnt_r,  err_cnt_s;
    logic [WIDTH-1:0] fail_a_r,   fail_a_s;
    logic [WIDTH-1:0] fail_b_r,   fail_b_s;
    logic             fail_vld_r, fail_vld_s;
    logic             mismatch_s;
    logic             last_vec_s;
    logic             finish_s;

    // Next-state and next-output computation for the sweep FSM.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        op_a_s     = op_a_r;
        op_b_s     = op_b_r;
        busy_s     = busy_r;
        done_s     = done_r;
        pass_s     = pass_r;
        err_cnt_s  = err_cnt_r;
        fail_a_s   = fail_a_r;
        fail_b_s   = fail_b_r;
        fail_vld_s = fail_vld_r;
        finish_s   = 1'b0;
        mismatch_s = ({bus.cout_in, bus.sum_in} != expected_sum(op_a_r, op_b_r));
        last_vec_s = (op_a_r == OP_ONES) && (op_b_r == OP_ONES);

        case (state_r)
            ST_IDLE, ST_DONE: begin
                // A new sweep wipes every trace of the previous one on the start edge.
                if (bus.start) begin
                    state_s    = ST_SETTLE;
                    cnt_s      = 8'd0;
                    op_a_s     = OP_ZERO;
                    op_b_s     = OP_ZERO;
                    busy_s     = 1'b1;
                    done_s     = 1'b0;
                    pass_s     = 1'b0;
                    err_cnt_s  = ERR_ZERO;
                    fail_a_s   = OP_ZERO;
                    fail_b_s   = OP_ZERO;
                    fail_vld_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end

            ST_SETTLE: begin
                if (cnt_r >= SETTLE_LAST) begin
                    state_s = ST_CHECK;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s   = cnt_r + 8'd1;
                end
            end

            ST_CHECK: begin
                if (mismatch_s) begin
                    err_cnt_s = sat_inc(err_cnt_r);
                    if (!fail_vld_r) begin
                        fail_a_s   = op_a_r;
                        fail_b_s   = op_b_r;
                        fail_vld_s = 1'b1;
                    end else begin
                        fail_vld_s = fail_vld_r;
                    end
                end else begin
                    err_cnt_s = err_cnt_r;
                end

`ifdef BINADD_SELFTEST_HALT_ON_ERR_EN
                finish_s = last_vec_s || mismatch_s;
`else
                finish_s = last_vec_s;
`endif

                // Operands stay put when finishing so the board shows the last or failing vector.
                if (finish_s) begin
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (err_cnt_s == ERR_ZERO);
                end else begin
                    state_s = ST_SETTLE;
                    if (op_b_r == OP_ONES) begin
                        op_b_s = OP_ZERO;
                        op_a_s = op_a_r + OP_ONE;
                    end else begin
                        op_b_s = op_b_r + OP_ONE;
                    end
                end
            end

            default: begin
                state_s    = ST_IDLE;
                cnt_s      = 8'd0;
                op_a_s     = OP_ZERO;
                op_b_s     = OP_ZERO;
                busy_s     = 1'b0;
                done_s     = 1'b0;
                pass_s     = 1'b0;
                err_cnt_s  = ERR_ZERO;
                fail_a_s   = OP_ZERO;
                fail_b_s   = OP_ZERO;
                fail_vld_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            op_a_r     <= OP_ZERO;
            op_b_r     <= OP_ZERO;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
            err_cnt_r  <= ERR_ZERO;
            fail_a_r   <= OP_ZERO;
            fail_b_r   <= OP_ZERO;
            fail_vld_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            op_a_r     <= op_a_s;
            op_b_r     <= op_b_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            pass_r     <= pass_s;
            err_cnt_r  <= err_cnt_s;
            fail_a_r   <= fail_a_s;
            fail_b_r   <= fail_b_s;
            fail_vld_r <= fail_vld_s;
        end
    end

    assign bus.op_a     = op_a_r;
    assign bus.op_b     = op_b_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.pass     = pass_r;
    assign bus.err_cnt  = err_cnt_r;
    assign bus.fail_a   = fail_a_r;
    assign bus.fail_b   = fail_b_r;
    assign bus.fail_vld = fail_vld_r;

endmodule

// File: tb/tb_binadd_selftest.sv
// Directed bench for binadd_selftest: faulty adder models drive sum/carry, outcomes checked from a table.
module tb_binadd_selftest;

    logic clk;
    logic rst_n;
    int   mode;
    int   mode2;
    int   n_pass;
    int   n_total;

    binadd_selftest_if #(.WIDTH(2), .ERR_W(8)) bus ();
    binadd_selftest_if #(.WIDTH(2), .ERR_W(2)) bus2 ();

    binadd_selftest #(.WIDTH(2), .SETTLE_CYC(4), .ERR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    binadd_selftest #(.WIDTH(2), .SETTLE_CYC(4), .ERR_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder models: 0 good, 1 COut stuck 0, 2 S inverted, 3 S bit0 stuck 1.
    function automatic logic [2:0] adder_model(input int m, input logic [1:0] a, input logic [1:0] b);
        logic [2:0] t;
        t = {1'b0, a} + {1'b0, b};
        case (m)
            1:       return {1'b0, t[1:0]};
            2:       return {t[2], ~t[1:0]};
            3:       return {t[2], t[1], 1'b1};
            default: return t;
        endcase
    endfunction

    always_comb begin
        {bus.cout_in, bus.sum_in}   = adder_model(mode, bus.op_a, bus.op_b);
        {bus2.cout_in, bus2.sum_in} = adder_model(mode2, bus2.op_a, bus2.op_b);
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    typedef struct {
        int         mode;
        int         cycles;
        int         exp_pass;
        int         exp_err;
        int         exp_fvld;
        int         fa;
        int         fb;
        int         oa;
        int         ob;
    } vec_t;

    vec_t tbl[4];

    // Pulse start for one cycle; returns at the falling edge right after the start edge.
    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_ack", {bus.busy, bus.done}, 2);
    endtask

    task automatic run_row(input int r);
        int k;
        int busy_cnt;
        int order_err;
        mode      = tbl[r].mode;
        k         = 0;
        busy_cnt  = 0;
        order_err = 0;
        pulse_start();
        while (!bus.done && k < 200) begin
            if (bus.busy) busy_cnt++;
            if ({bus.op_a, bus.op_b} != 4'(k / 5)) order_err++;
            @(negedge clk);
            k++;
        end
        check($sformatf("row%0d_cycles", r), k, tbl[r].cycles);
        check($sformatf("row%0d_busy_cnt", r), busy_cnt, tbl[r].cycles);
        check($sformatf("row%0d_visit_order", r), order_err, 0);
        check($sformatf("row%0d_pass", r), int'(bus.pass), tbl[r].exp_pass);
        check($sformatf("row%0d_err_cnt", r), int'(bus.err_cnt), tbl[r].exp_err);
        check($sformatf("row%0d_fail_vld", r), int'(bus.fail_vld), tbl[r].exp_fvld);
        check($sformatf("row%0d_fail_ab", r), int'({bus.fail_a, bus.fail_b}), tbl[r].fa * 4 + tbl[r].fb);
        check($sformatf("row%0d_op_ab", r), int'({bus.op_a, bus.op_b}), tbl[r].oa * 4 + tbl[r].ob);
        repeat (3) @(negedge clk);
        check($sformatf("row%0d_done_hold", r), {bus.done, bus.busy}, 2);
    endtask

    initial begin
        int k;
        n_pass     = 0;
        n_total    = 0;
        mode       = 0;
        mode2      = 2;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus2.start = 1'b0;

`ifdef BINADD_SELFTEST_HALT_ON_ERR_EN
        tbl[0] = '{0, 80, 1, 0,  0, 0, 0, 3, 3};
        tbl[1] = '{1, 40, 0, 1,  1, 1, 3, 1, 3};
        tbl[2] = '{2,  5, 0, 1,  1, 0, 0, 0, 0};
        tbl[3] = '{3,  5, 0, 1,  1, 0, 0, 0, 0};
`else
        tbl[0] = '{0, 80, 1, 0,  0, 0, 0, 3, 3};
        tbl[1] = '{1, 80, 0, 6,  1, 1, 3, 3, 3};
        tbl[2] = '{2, 80, 0, 16, 1, 0, 0, 3, 3};
        tbl[3] = '{3, 80, 0, 8,  1, 0, 0, 3, 3};
`endif

        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({bus.busy, bus.done, bus.pass, bus.err_cnt, bus.fail_vld,
                    bus.fail_a, bus.fail_b, bus.op_a, bus.op_b}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", {bus.busy, bus.done}, 0);

        for (int r = 0; r < 4; r++) run_row(r);

        // A second start mid-sweep must not restart the sweep.
        mode = 0;
        pulse_start();
        k = 0;
        while (!bus.done && k < 200) begin
            @(negedge clk);
            k++;
            bus.start = (k == 30);
        end
        bus.start = 1'b0;
        check("restart_ignored_cycles", k, 80);
        check("restart_ignored_pass", int'(bus.pass), 1);

        // Mid-sweep reset with a faulty adder: everything clears at once, then a clean sweep.
        mode = 1;
        pulse_start();
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              int'({bus.busy, bus.done, bus.pass, bus.err_cnt, bus.fail_vld,
                    bus.fail_a, bus.fail_b, bus.op_a, bus.op_b}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {bus.busy, bus.done}, 0);
        run_row(0);

        // Narrow error counter saturates instead of wrapping.
        @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        k = 0;
        while (!bus2.done && k < 200) begin
            @(negedge clk);
            k++;
        end
`ifdef BINADD_SELFTEST_HALT_ON_ERR_EN
        check("sat_err_cnt", int'(bus2.err_cnt), 1);
        check("sat_cycles", k, 5);
`else
        check("sat_err_cnt", int'(bus2.err_cnt), 3);
        check("sat_cycles", k, 80);
`endif
        check("sat_pass", int'(bus2.pass), 0);
        check("sat_fail_vld", int'(bus2.fail_vld), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/binadd_selftest.md
Name: binadd_selftest

Overview:
- On-board stimulus and checker for the combinational BinAdd adder on the Cmod A7-35T.
- Drives every operand pair into the adder, samples sum and carry-out, and compares them with the expected result.
- Reports pass/fail and the error count for LEDs or an ILA, so the adder can be exercised in hardware without a simulator.

Parameters:
- WIDTH, 2, operand width in bits; sweep covers 2^(2*WIDTH) vectors.
- SETTLE_CYC, 4, clock cycles operands are held before sampling; legal range 1..255.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a sweep when idle.
- op_a  out  WIDTH  operand A to adder.
- op_b  out  WIDTH  operand B to adder.
- sum_in  in  WIDTH  adder S output.
- cout_in  in  1  adder COut output.
- busy  out  1  high while a sweep is running.
- done  out  1  high after a sweep completes; held until next start or reset.
- pass  out  1  done and zero errors.
- err_cnt  out  ERR_W  mismatch count, saturating at all-ones.
- fail_a  out  WIDTH  op_a of first mismatch.
- fail_b  out  WIDTH  op_b of first mismatch.
- fail_vld  out  1  fail_a/fail_b hold a captured vector.

Behaviour:
- Reset (async assert, sync deassert by caller) clears all outputs and state to zero. FSM enters IDLE.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 at an edge moves to SETTLE.
  - op_a, op_b, err_cnt, fail_* and fail_vld are cleared at that same edge.
  - busy=1 from the next cycle.
- SETTLE:
  - Operands are held constant. A settle counter runs SETTLE_CYC cycles, then moves to CHECK.
- CHECK (one cycle):
  - Compares {cout_in,sum_in} against op_a+op_b computed at WIDTH+1 bits, zero-extended.
  - On mismatch: err_cnt increments (saturating). If fail_vld=0, capture op_a/op_b into fail_a/fail_b and set fail_vld.
  - Then advances the operands and returns to SETTLE, or goes to DONE.
- Operand advance is B-major inner loop:
  - op_b increments.
  - When op_b was all-ones it wraps to 0 and op_a increments.
  - When both were all-ones, go to DONE and leave operands at all-ones.
- Timing: each vector takes SETTLE_CYC+1 cycles. A full sweep takes 2^(2*WIDTH)*(SETTLE_CYC+1) cycles; defaults give 80 cycles from the start edge to done.
- DONE:
  - busy=0, done=1, pass=(err_cnt==0).
  - start re-enters SETTLE with full clearing as in IDLE; done drops on that edge.
- start while busy is ignored and does not restart the sweep.
- Simultaneous mismatch and saturated err_cnt: err_cnt stays all-ones; first-fail capture still applies.
- rst_n low mid-sweep aborts immediately: outputs zero, IDLE, no partial result retained.

Optional Feature:
- Macro BINADD_SELFTEST_HALT_ON_ERR_EN.
- Defined: the first mismatch in CHECK goes straight to DONE instead of advancing.
  - err_cnt=1, pass=0.
  - op_a/op_b remain on the failing vector, so the board shows the offending inputs.
- Undefined: the sweep always runs all vectors, as described above.

Test Plan:
- Correct adder model, defaults, pulse start -> busy for 80 cycles; op pairs visited in order (0,0),(0,1)..(3,3); done=1, pass=1, err_cnt=0, fail_vld=0.
- Adder model with COut stuck at 0 -> six mismatches (pairs summing >=4: (1,3),(2,2),(2,3),(3,1),(3,2),(3,3)); err_cnt=6, pass=0, fail_a=1, fail_b=3.
- Start pulsed again at cycle 30 of a sweep -> ignored; done still arrives 80 cycles after the original start.
- rst_n pulsed low at cycle 40 -> all outputs 0 asynchronously; after release a new start gives a clean full sweep with pass=1.
- ERR_W=2, model with S inverted -> err_cnt saturates at 3, no wrap; pass=0.
- With BINADD_SELFTEST_HALT_ON_ERR_EN and S bit0 stuck at 1 -> stops at vector (0,0): done=1, err_cnt=1, op_a=0, op_b=0, fail_vld=1.
